// File: rtl/lifo_stack_pkg.sv
// Shared types and sizing helpers for the LIFO stack.
// Op encoding and counter/address width derivation.
package lifo_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_TOS  = 3'd3,
    OP_XCHG = 3'd4
  } op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Controller-facing strobe and status bundle of the stack.
// master = controller, slave = stack.
interface lifo_stack_if
  import lifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic              push;
  logic              pop;
  logic              tos;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              d_valid;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output push, pop, tos, d_in,
    input  d_out, d_valid, count,
    input  empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, tos, d_in,
    output d_out, d_valid, count,
    output empty, full,
    output overflow, underflow
  );

endinterface

// File: rtl/lifo_stack_mem.sv
// Stack storage: one synchronous write port, one async read port.
// Contents are never cleared.
module lifo_stack_mem
  import lifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack.sv
// Parametrised stack: op decode, occupancy counter,
// sticky error flags and the registered read port.
module lifo_stack
  import lifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
) (
  input  logic        clk,
  input  logic        rst,
  lifo_stack_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int AW    = addr_w(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_dv;
  logic              r_ovf;
  logic              r_unf;

  op_e               w_op;
  logic              w_peek;
  logic              w_empty;
  logic              w_full;
  logic              w_rd;
  logic              w_we;
  logic              w_wr_top;
  logic              w_set_ovf;
  logic              w_set_unf;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [AW-1:0]     w_raddr;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // Top entry sits at count-1; only used when not empty.
  assign w_raddr = AW'(r_count - ONE_C);
  assign w_waddr = w_wr_top ? w_raddr
                            : AW'(r_count);

  always_comb begin
    w_op = OP_NONE;
    unique case (1'b1)
      bus.push && bus.pop:
        w_op = OP_XCHG;
      bus.pop && !bus.push:
        w_op = OP_POP;
      bus.push && !bus.pop:
        w_op = OP_PUSH;
      bus.tos && !bus.push && !bus.pop:
        w_op = OP_TOS;
      default: ;
    endcase
  end

  // tos alongside a push reads the pre-push top.
  assign w_peek = bus.tos && bus.push && !bus.pop;

  always_comb begin
    w_rd      = w_peek && !w_empty;
    w_we      = 1'b0;
    w_wr_top  = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    w_cnt_nxt = r_count;
    unique case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we      = 1'b1;
          w_cnt_nxt = r_count + ONE_C;
        end else begin
          w_set_ovf = 1'b1;
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_rd      = 1'b1;
          w_cnt_nxt = r_count - ONE_C;
        end else begin
          w_set_unf = 1'b1;
        end
      end
      OP_TOS: begin
        w_rd = !w_empty;
      end
      OP_XCHG: begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_rd     = 1'b1;
          w_wr_top = 1'b1;
        end else begin
          w_set_unf = 1'b1;
          w_cnt_nxt = r_count + ONE_C;
        end
      end
      default: ;
    endcase
  end

  lifo_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we && rst),
    .i_waddr (w_waddr),
    .i_wdata (bus.d_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_dv    <= w_rd;
      if (w_rd) begin
        r_dout <= w_rdata;
      end
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_set_unf) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign bus.d_out     = r_dout;
  assign bus.d_valid   = r_dv;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_ovf;
  assign bus.underflow = r_unf;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: 8x32 and 16x5 instances.
// Table-driven vectors plus hand sequences for fill/reset.
module tb_lifo_stack;
  import lifo_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lifo_stack_if #(.DATA_W(8),  .DEPTH(32)) if_a();
  lifo_stack_if #(.DATA_W(16), .DEPTH(5))  if_b();

  lifo_stack #(.DATA_W(8), .DEPTH(32)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  lifo_stack #(.DATA_W(16), .DEPTH(5)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       push;
    logic       pop;
    logic       tos;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dv;
    int         cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic cyc_a(input logic p, input logic q,
                       input logic t, input logic [7:0] d);
    if_a.push = p;
    if_a.pop  = q;
    if_a.tos  = t;
    if_a.d_in = d;
    @(posedge clk);
    #1;
    if_a.push = 1'b0;
    if_a.pop  = 1'b0;
    if_a.tos  = 1'b0;
  endtask

  task automatic cyc_b(input logic p, input logic q,
                       input logic [15:0] d);
    if_b.push = p;
    if_b.pop  = q;
    if_b.tos  = 1'b0;
    if_b.d_in = d;
    @(posedge clk);
    #1;
    if_b.push = 1'b0;
    if_b.pop  = 1'b0;
  endtask

  task automatic exp_a(input string tag, input logic [7:0] dout,
                       input logic dv, input int cnt,
                       input logic ovf, input logic unf);
    chk({tag, " a.d_out"},   32'(if_a.d_out), 32'(dout));
    chk({tag, " a.d_valid"}, 32'(if_a.d_valid), 32'(dv));
    chk({tag, " a.count"},   32'(if_a.count), 32'(cnt));
    chk({tag, " a.empty"},   32'(if_a.empty), 32'(cnt == 0));
    chk({tag, " a.full"},    32'(if_a.full), 32'(cnt == 32));
    chk({tag, " a.ovf"},     32'(if_a.overflow), 32'(ovf));
    chk({tag, " a.unf"},     32'(if_a.underflow), 32'(unf));
  endtask

  task automatic exp_b(input string tag, input logic [15:0] dout,
                       input logic dv, input int cnt,
                       input logic ovf, input logic unf);
    chk({tag, " b.d_out"},   32'(if_b.d_out), 32'(dout));
    chk({tag, " b.d_valid"}, 32'(if_b.d_valid), 32'(dv));
    chk({tag, " b.count"},   32'(if_b.count), 32'(cnt));
    chk({tag, " b.empty"},   32'(if_b.empty), 32'(cnt == 0));
    chk({tag, " b.full"},    32'(if_b.full), 32'(cnt == 5));
    chk({tag, " b.ovf"},     32'(if_b.overflow), 32'(ovf));
    chk({tag, " b.unf"},     32'(if_b.underflow), 32'(unf));
  endtask

  initial begin
    // push pop tos din | dout dv cnt ovf unf
    vecs[0]  = '{1, 0, 0, 8'h11, 8'h00, 0, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'h22, 8'h00, 0, 2, 0, 0};
    vecs[2]  = '{1, 0, 0, 8'h33, 8'h00, 0, 3, 0, 0};
    vecs[3]  = '{0, 1, 0, 8'h00, 8'h33, 1, 2, 0, 0};
    vecs[4]  = '{0, 1, 0, 8'h00, 8'h22, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 0, 8'h00, 8'h11, 1, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 8'h00, 8'h11, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 8'h00, 8'h11, 0, 0, 0, 1};
    vecs[8]  = '{1, 1, 0, 8'h5A, 8'h11, 0, 1, 0, 1};
    vecs[9]  = '{0, 1, 0, 8'h00, 8'h5A, 1, 0, 0, 1};
    vecs[10] = '{1, 0, 0, 8'hA5, 8'h5A, 0, 1, 0, 1};
    vecs[11] = '{0, 0, 1, 8'h00, 8'hA5, 1, 1, 0, 1};
    vecs[12] = '{0, 0, 1, 8'h00, 8'hA5, 1, 1, 0, 1};
    vecs[13] = '{1, 1, 0, 8'h3C, 8'hA5, 1, 1, 0, 1};
    vecs[14] = '{0, 1, 0, 8'h00, 8'h3C, 1, 0, 0, 1};
    vecs[15] = '{0, 0, 1, 8'h00, 8'h3C, 0, 0, 0, 1};
    vecs[16] = '{1, 0, 1, 8'h01, 8'h3C, 0, 1, 0, 1};
    vecs[17] = '{1, 0, 1, 8'h02, 8'h01, 1, 2, 0, 1};

    if_a.push = 1'b0; if_a.pop = 1'b0;
    if_a.tos  = 1'b0; if_a.d_in = '0;
    if_b.push = 1'b0; if_b.pop = 1'b0;
    if_b.tos  = 1'b0; if_b.d_in = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_a("reset", 8'h00, 0, 0, 0, 0);
    exp_b("reset", 16'h0000, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      cyc_a(vecs[i].push, vecs[i].pop, vecs[i].tos, vecs[i].din);
      exp_a($sformatf("vec%0d", i), vecs[i].dout, vecs[i].dv,
            vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
    end

    rst = 1'b0;
    cyc_a(0, 0, 0, 8'h00);
    rst = 1'b1;
    exp_a("rst2", 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      cyc_a(1, 0, 0, 8'(8'h80 + i));
    end
    exp_a("fill", 8'h00, 0, 32, 0, 0);
    cyc_a(1, 1, 0, 8'h77);
    exp_a("xchg_full", 8'h9F, 1, 32, 0, 0);
    cyc_a(0, 1, 0, 8'h00);
    exp_a("pop77", 8'h77, 1, 31, 0, 0);
    cyc_a(1, 0, 0, 8'h9F);
    exp_a("refill", 8'h77, 0, 32, 0, 0);
    cyc_a(1, 0, 0, 8'hFF);
    exp_a("ovf", 8'h77, 0, 32, 1, 0);
    cyc_a(0, 1, 0, 8'h00);
    exp_a("pop_after_ovf", 8'h9F, 1, 31, 1, 0);
    for (int i = 0; i < 26; i++) begin
      cyc_a(0, 1, 0, 8'h00);
    end
    exp_a("drain5", 8'h85, 1, 5, 1, 0);

    rst = 1'b0;
    cyc_a(1, 0, 0, 8'hEE);
    rst = 1'b1;
    exp_a("rst_mid", 8'h00, 0, 0, 0, 0);
    cyc_a(0, 1, 0, 8'h00);
    exp_a("push_ignored", 8'h00, 0, 0, 0, 1);

    for (int i = 0; i < 5; i++) begin
      cyc_b(1, 0, 16'(16'h1001 + i));
    end
    exp_b("fill", 16'h0000, 0, 5, 0, 0);
    cyc_b(1, 0, 16'hFFFF);
    exp_b("ovf", 16'h0000, 0, 5, 1, 0);
    cyc_b(0, 1, 16'h0000);
    exp_b("pop", 16'h1005, 1, 4, 1, 0);
    cyc_b(1, 0, 16'h1005);
    exp_b("refill", 16'h1005, 0, 5, 1, 0);
    cyc_b(1, 1, 16'h0777);
    exp_b("xchg", 16'h1005, 1, 5, 1, 0);

    rst = 1'b0;
    cyc_b(1, 0, 16'h2222);
    rst = 1'b1;
    exp_b("rst_mid", 16'h0000, 0, 0, 0, 0);
    cyc_b(1, 0, 16'hABCD);
    exp_b("push", 16'h0000, 0, 1, 0, 0);
    cyc_b(0, 1, 16'h0000);
    exp_b("pop_abcd", 16'hABCD, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
Parametrised synchronous hardware stack. Successor to the fixed 8-bit/32-entry stack used by the stack-based datapath. Adds configurable width and depth, a registered read port, full/empty/occupancy status, sticky overflow/underflow flags and a single-cycle exchange operation (push and pop in the same cycle). It sits beside the data memory and register file and is driven by the controller's push/pop/tos strobes.

Parameters:
DATA_W, 8, width of each stack entry in bits
DEPTH, 32, number of entries (any value >= 2; need not be a power of two)
CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived; not overridden)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk
push  input  1  write d_in onto the stack this cycle
pop  input  1  remove the top entry and return it on d_out
tos  input  1  return the top entry on d_out without removing it
d_in  input  DATA_W  data to push
d_out  output  DATA_W  registered read data
d_valid  output  1  d_out was updated by the previous cycle's pop/tos
count  output  CNT_W  current number of entries, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky; a push was rejected
underflow  output  1  sticky; a pop was rejected

Behaviour:
- Reset (rst == 0 at a clock edge): count = 0, d_out = 0, d_valid = 0, overflow = 0, underflow = 0. Storage contents are not cleared. Reset overrides all strobes in the same cycle.
- Storage: DEPTH x DATA_W array. Occupied entries are 0..count-1; the top is entry count-1. The stack does not wrap. count saturates at 0 and DEPTH.
- empty and full are combinational decodes of the count register.
- Read latency is one cycle. d_out and d_valid are registered. d_valid is high for exactly one cycle after an accepted read. d_out holds its value until the next accepted read.
- Operation decode, per cycle, on state before the edge:
  - push only, not full: mem[count] <= d_in; count += 1.
  - push only, full: no write; count unchanged; overflow <= 1.
  - pop only, not empty: d_out <= mem[count-1]; d_valid <= 1; count -= 1.
  - pop only, empty: d_out unchanged; d_valid <= 0; underflow <= 1.
  - tos only, not empty: d_out <= mem[count-1]; d_valid <= 1; count unchanged.
  - tos only, empty: d_valid <= 0; no flag set.
  - push + pop, not empty (exchange; legal when full): d_out <= old mem[count-1]; mem[count-1] <= d_in; d_valid <= 1; count unchanged; no flags.
  - push + pop, empty: the pop is rejected and underflow <= 1. The push is accepted: mem[0] <= d_in; count = 1.
  - tos together with pop is treated as pop. tos together with push returns the pre-push top, then the push proceeds as push only.
- Flags are sticky. They are cleared only by reset.
- Idle cycle (no strobes): d_valid <= 0; all other state holds.

Decomposition:
- Shared package lifo_pkg holds: the op encoding typedef (OP_NONE, OP_PUSH, OP_POP, OP_TOS, OP_XCHG) and a helper that derives CNT_W.
- One sub-module, lifo_stack_mem: DEPTH x DATA_W array with one write port and one asynchronous read port at address count-1. No reset.
- The top level holds the decode, the counter, the flags and the d_out register.

Test Plan:
- Reset, then push 8'h11, 8'h22, 8'h33, then pop x3 -> d_out = 33, 22, 11 on the cycle after each pop with d_valid = 1; count ends 0; empty = 1.
- Fill with DEPTH pushes, then push 8'hFF -> full = 1, count = DEPTH, overflow = 1. A following pop returns the last accepted value, not FF.
- Pop on empty -> underflow = 1, d_valid = 0, d_out unchanged, count = 0. Push+pop on empty with d_in = 8'h5A -> underflow = 1, count = 1; a later pop returns 5A.
- Push A5, then tos x2 -> d_out = A5 twice, count stays 1. Then push+pop with d_in = 3C -> d_out = A5, count = 1; the next pop returns 3C.
- When full, push+pop with d_in = 77 -> no overflow, count = DEPTH, d_out = old top; pop returns 77.
- Drive rst = 0 for one cycle mid-sequence (count = 5, overflow = 1) while push is high -> count = 0, flags = 0, d_valid = 0, push ignored. Repeat with DATA_W = 16, DEPTH = 5 (non-power-of-two).
